// File: rtl/instr_sequencer.sv
// Instruction sequencer: holds a small program store and issues words to the datapath in order.
// Define INSTR_SEQ_STEP_EN to add the step_i port and a WAIT_STEP gate in front of every issue.
module instr_sequencer #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
`ifdef INSTR_SEQ_STEP_EN
  input  logic              step_i,
`endif
  input  logic              load_we_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [31:0]       load_data_i,
  input  logic [ADDR_W:0]   prog_len_i,
  output logic [31:0]       instr_o,
  output logic              instr_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_ISSUE    = 3'd2,
    S_MEM_HOLD = 3'd3,
    S_DONE     = 3'd4
`ifdef INSTR_SEQ_STEP_EN
    , S_WAIT_STEP = 3'd5
`endif
  } state_e;

  localparam logic [5:0]        OP_LW   = 6'b100010;
  localparam logic [5:0]        OP_SW   = 6'b100100;
  localparam logic [5:0]        OP_HALT = 6'b111111;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  function automatic logic is_mem_op(input logic [31:0] w);
    is_mem_op = (w[31:26] == OP_LW) || (w[31:26] == OP_SW);
  endfunction

  function automatic logic is_halt_op(input logic [31:0] w);
    is_halt_op = (w[31:26] == OP_HALT);
  endfunction

  logic [31:0]       mem_q [DEPTH];
  state_e            state_q;
  logic [31:0]       instr_q;
  logic              valid_q;
  logic [ADDR_W-1:0] pc_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W:0]   len_q;

  logic [ADDR_W:0]   len_sel_s;
  logic              last_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [31:0]       load_word_s;
  logic              load_halt_s;
  logic [31:0]       ld_instr_s;
  state_e            ld_state_s;

  // Advancing from ISSUE/MEM_HOLD fetches the following word; FETCH and WAIT_STEP fetch mem[pc].
  assign len_sel_s   = (prog_len_i > DEPTH_W) ? DEPTH_W : prog_len_i;
  assign last_s      = (({1'b0, pc_q} + LEN_ONE) == len_q);
  assign pc_inc_s    = pc_q + PC_ONE;
  assign load_word_s = (state_q == S_ISSUE || state_q == S_MEM_HOLD) ? mem_q[pc_inc_s] : mem_q[pc_q];
  assign load_halt_s = is_halt_op(load_word_s);
  assign ld_instr_s  = load_halt_s ? 32'd0 : load_word_s;
  assign ld_state_s  = load_halt_s ? S_DONE : S_ISSUE;

  // Program store: writable only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (load_we_i && !busy_q) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      pc_q    <= {ADDR_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= {(ADDR_W+1){1'b0}};
    end else if (abort_i) begin
      state_q <= S_IDLE;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      pc_q    <= {ADDR_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            len_q   <= len_sel_s;
            pc_q    <= {ADDR_W{1'b0}};
            busy_q  <= 1'b1;
            state_q <= (len_sel_s == {(ADDR_W+1){1'b0}}) ? S_DONE : S_FETCH;
            done_q  <= (len_sel_s == {(ADDR_W+1){1'b0}});
          end
        end
        S_FETCH: begin
`ifdef INSTR_SEQ_STEP_EN
          state_q <= S_WAIT_STEP;
`else
          instr_q <= ld_instr_s;
          valid_q <= !load_halt_s;
          done_q  <= load_halt_s;
          state_q <= ld_state_s;
`endif
        end
`ifdef INSTR_SEQ_STEP_EN
        S_WAIT_STEP: begin
          if (step_i) begin
            instr_q <= ld_instr_s;
            valid_q <= !load_halt_s;
            done_q  <= load_halt_s;
            state_q <= ld_state_s;
          end
        end
`endif
        S_ISSUE, S_MEM_HOLD: begin
          if (state_q == S_ISSUE && is_mem_op(instr_q)) begin
            state_q <= S_MEM_HOLD;
          end else if (last_s) begin
            state_q <= S_DONE;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pc_q <= pc_inc_s;
`ifdef INSTR_SEQ_STEP_EN
            state_q <= S_WAIT_STEP;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
`else
            instr_q <= ld_instr_s;
            valid_q <= !load_halt_s;
            done_q  <= load_halt_s;
            state_q <= ld_state_s;
`endif
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pc_q    <= {ADDR_W{1'b0}};
        end
        default: begin
          state_q <= S_IDLE;
          instr_q <= 32'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pc_q    <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised self-checking bench for instr_sequencer against a per-cycle trace model.
`timescale 1ns/1ps
module tb_instr_sequencer;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam logic [5:0]  OP_LW   = 6'b100010;
  localparam logic [5:0]  OP_SW   = 6'b100100;
  localparam logic [5:0]  OP_HALT = 6'b111111;
  localparam logic [31:0] W_ADD   = 32'h0123_4020;
  localparam logic [31:0] W_SUB   = 32'h0234_5822;
  localparam logic [31:0] W_XOR   = 32'h0345_6826;
  localparam logic [31:0] W_LW    = 32'h8822_0004;
  localparam logic [31:0] W_HALT  = 32'hFC00_0000;

  logic          clk = 1'b0;
  logic          rst, start, abort, load_we;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [AW:0]   prog_len;
  logic [31:0]   instr;
  logic          instr_valid, busy, done;
  logic [AW-1:0] pc;
`ifdef INSTR_SEQ_STEP_EN
  logic          step = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem_m [DEPTH];

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    int          pc;
    logic        busy;
    logic        done;
  } cyc_t;
  cyc_t exp_q[$];

  always #5 clk = ~clk;

  instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
`ifdef INSTR_SEQ_STEP_EN
    .step_i(step),
`endif
    .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
    .prog_len_i(prog_len), .instr_o(instr), .instr_valid_o(instr_valid),
    .pc_o(pc), .busy_o(busy), .done_o(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(instr_valid), 32'd0);
    check({tag, ".instr"}, instr, 32'd0);
    check({tag, ".busy"},  32'(busy), 32'd0);
    check({tag, ".done"},  32'(done), 32'd0);
  endtask

  task automatic load_words(input int n);
    for (int a = 0; a < n; a++) begin
      load_we = 1'b1; load_addr = AW'(a); load_data = mem_m[a];
      tick();
    end
    load_we = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 19);
    if (k < 4) w[31:26] = OP_LW;
    else if (k < 7) w[31:26] = OP_SW;
    else if (k == 7) w[31:26] = OP_HALT;
    else if (w[31:26] == OP_HALT) w[31:26] = 6'b000000;
    return w;
  endfunction

`ifndef INSTR_SEQ_STEP_EN
  function automatic void push_exp(input logic v, input logic [31:0] w, input int p,
                                   input logic b, input logic d);
    cyc_t c;
    c.valid = v; c.instr = w; c.pc = p; c.busy = b; c.done = d;
    exp_q.push_back(c);
  endfunction

  // Expected output per cycle after the start edge: one fetch cycle, each word once
  // (memory ops twice), stop at HALT or the length, then one done cycle.
  function automatic void build(input int len);
    int l;
    logic [31:0] w;
    exp_q.delete();
    l = (len > DEPTH) ? DEPTH : len;
    if (l != 0) begin
      push_exp(1'b0, 32'd0, 0, 1'b1, 1'b0);
      for (int i = 0; i < l; i++) begin
        w = mem_m[i];
        if (w[31:26] == OP_HALT) break;
        push_exp(1'b1, w, i, 1'b1, 1'b0);
        if (w[31:26] == OP_LW || w[31:26] == OP_SW) push_exp(1'b1, w, i, 1'b1, 1'b0);
      end
    end
    push_exp(1'b0, 32'd0, 0, 1'b1, 1'b1);
  endfunction

  // Runs one program; while busy, drives ignored store writes and starts.
  task automatic run(input string tag, input int len, input int abort_at);
    cyc_t e;
    build(len);
    start = 1'b1; prog_len = (AW+1)'(len);
    tick();
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      check({tag, ".valid"}, 32'(instr_valid), 32'(e.valid));
      check({tag, ".instr"}, instr, e.instr);
      check({tag, ".busy"},  32'(busy), 32'(e.busy));
      check({tag, ".done"},  32'(done), 32'(e.done));
      if (e.valid) check({tag, ".pc"}, 32'(pc), 32'(e.pc));
      if (i == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle({tag, ".abort"});
        check({tag, ".abort.pc"}, 32'(pc), 32'd0);
        tick();
        check_idle({tag, ".post_abort"});
        return;
      end
      load_we = 1'b1; load_addr = AW'($urandom); load_data = $urandom;
      start = 1'($urandom); prog_len = (AW+1)'($urandom);
      tick();
      load_we = 1'b0; start = 1'b0;
    end
    check_idle({tag, ".end"});
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; load_we = 1'b0;
    load_addr = '0; load_data = '0; prog_len = '0;
    #3 rst = 1'b0;
    #1;
    check_idle("reset");
    check("reset.pc", 32'(pc), 32'd0);
    tick();
    rst = 1'b1;
    tick();

`ifndef INSTR_SEQ_STEP_EN
    mem_m[0] = W_ADD; mem_m[1] = W_SUB; mem_m[2] = W_XOR;
    load_words(3);
    run("three", 3, -1);
    mem_m[0] = W_LW; mem_m[1] = W_ADD;
    load_words(2);
    run("lw_add", 2, -1);
    mem_m[0] = W_ADD; mem_m[1] = W_HALT; mem_m[2] = W_SUB;
    load_words(3);
    run("halt", 3, -1);
    run("len0", 0, -1);
    for (int a = 0; a < DEPTH; a++) mem_m[a] = W_ADD + 32'(a);
    load_words(DEPTH);
    run("full", DEPTH, -1);
    run("clamp", 40, -1);
    run("abort3", DEPTH, 3);
    start = 1'b1; abort = 1'b1; prog_len = 6'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    check_idle("start_abort");
    tick();
    check_idle("start_abort2");
`else
    mem_m[0] = W_ADD; mem_m[1] = W_SUB;
    load_words(2);
    start = 1'b1; prog_len = 6'd2;
    tick();
    start = 1'b0;
    check("step.fetch.busy", 32'(busy), 32'd1);
    check("step.fetch.valid", 32'(instr_valid), 32'd0);
    for (int s = 0; s < 2; s++) begin
      repeat (3) begin
        tick();
        check("step.wait.valid", 32'(instr_valid), 32'd0);
        check("step.wait.instr", instr, 32'd0);
        check("step.wait.busy", 32'(busy), 32'd1);
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step.issue.valid", 32'(instr_valid), 32'd1);
      check("step.issue.instr", instr, mem_m[s]);
      check("step.issue.pc", 32'(pc), 32'(s));
    end
    tick();
    check("step.done", 32'(done), 32'd1);
    tick();
    check_idle("step.end");
    mem_m[2] = W_XOR;
    load_words(3);
`endif

    // Asynchronous reset in the middle of a run, asserted between clock edges.
    mem_m[0] = W_ADD; mem_m[1] = W_SUB; mem_m[2] = W_XOR;
    load_words(3);
    start = 1'b1; prog_len = 6'd3;
    tick();
    start = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("midrst");
    check("midrst.pc", 32'(pc), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) begin
      tick();
      check_idle("midrst.after");
    end

`ifndef INSTR_SEQ_STEP_EN
    run("retained", 3, -1);
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int a = 0; a < DEPTH; a++) mem_m[a] = rand_word();
        load_words(DEPTH);
      end
      run("rand", $urandom_range(0, 40),
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
